// File: rtl/stepdown_tstate_sequencer.sv
// Switching-period sequencer for the stepdown gate stage: dead time, high-side on,
// dead time, low-side on. Enforces min-on blanking, max-on limiting and phase exclusion.
module stepdown_tstate_sequencer #(
    parameter int CNT_W       = 8,
    parameter int DEAD_CYC    = 4,
    parameter int MIN_ON      = 6,
    parameter int MAX_ON      = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pwm_set,
    input  logic comp_trip,
    input  logic zc_trip,
    output logic i0,
    output logic tstate0,
    output logic tstate1,
    output logic busy,
    output logic maxon_flag
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DT_HS = 3'd1,
        HS_ON = 3'd2,
        DT_LS = 3'd3,
        LS_ON = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, cnt_dec;
    logic             abort, abort_nxt;
    logic             maxon_set;

    logic [SYNC_STAGES-1:0] pwm_sr, comp_sr, zc_sr;
    logic                   pwm_sync, pwm_sync_d, comp_sync, zc_sync, pwm_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_sr     <= '0;
            comp_sr    <= '0;
            zc_sr      <= '0;
            pwm_sync_d <= 1'b0;
        end else begin
            pwm_sr     <= {pwm_sr[SYNC_STAGES-2:0], pwm_set};
            comp_sr    <= {comp_sr[SYNC_STAGES-2:0], comp_trip};
            zc_sr      <= {zc_sr[SYNC_STAGES-2:0], zc_trip};
            pwm_sync_d <= pwm_sync;
        end
    end

    assign pwm_sync  = pwm_sr[SYNC_STAGES-1];
    assign comp_sync = comp_sr[SYNC_STAGES-1];
    assign zc_sync   = zc_sr[SYNC_STAGES-1];
    assign pwm_edge  = pwm_sync & ~pwm_sync_d;

    // Counter saturates in both directions so a bad parameter set cannot wrap it.
    assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + CNT_W'(1);
    assign cnt_dec = (cnt == '0) ? cnt : cnt - CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_nxt = abort;
        maxon_set = 1'b0;
        case (state)
            IDLE: begin
                abort_nxt = 1'b0;
                if (en && pwm_edge) begin
                    state_nxt = DT_HS;
                    cnt_nxt   = DEAD_LD;
                end
            end
            DT_HS: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = HS_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end
            HS_ON: begin
                if (!en) begin
                    state_nxt = DT_LS;
                    cnt_nxt   = DEAD_LD;
                    abort_nxt = 1'b1;
                end else if ((cnt >= MIN_LAST) && comp_sync) begin
                    state_nxt = DT_LS;
                    cnt_nxt   = DEAD_LD;
                end else if (cnt == MAX_LAST) begin
                    state_nxt = DT_LS;
                    cnt_nxt   = DEAD_LD;
                    maxon_set = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            DT_LS: begin
                // The low-side dead time always runs to completion, even when aborting.
                if (cnt == '0) begin
                    cnt_nxt   = '0;
                    state_nxt = (abort || !en) ? IDLE : LS_ON;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end
            LS_ON: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (pwm_edge) begin
                    state_nxt = DT_HS;
                    cnt_nxt   = DEAD_LD;
                end else if (zc_sync) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            abort      <= 1'b0;
            i0         <= 1'b0;
            tstate0    <= 1'b0;
            tstate1    <= 1'b0;
            busy       <= 1'b0;
            maxon_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            abort      <= abort_nxt;
            i0         <= (state_nxt == HS_ON);
            tstate0    <= (state_nxt == HS_ON);
            tstate1    <= (state_nxt == LS_ON);
            busy       <= (state_nxt != IDLE);
            maxon_flag <= en ? (maxon_flag | maxon_set) : 1'b0;
        end
    end

endmodule
